// File: rtl/dram_arbiter_if.sv
// Requester and DRAM-controller signal bundle for dram_arbiter.
// master = arbiter view, slave = requester/controller environment view.
interface dram_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 128
);
    logic          P0_REQ, P1_REQ;
    logic          P0_WE,  P1_WE;
    logic [AW-1:0] P0_ADR, P1_ADR;
    logic [DW-1:0] P0_DIN, P1_DIN;
    logic          P0_ACK, P1_ACK;
    logic [DW-1:0] P0_DOUT, P1_DOUT;
    logic          P0_DVALID, P1_DVALID;
    logic [AW-1:0] D_ADR;
    logic [DW-1:0] D_DIN;
    logic          D_WE, D_RE;
    logic [DW-1:0] D_DOUT;
    logic          D_BUSY, D_DOUTVALID;

    modport master (
        input  P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADR, P1_ADR, P0_DIN, P1_DIN,
        output P0_ACK, P1_ACK, P0_DOUT, P1_DOUT, P0_DVALID, P1_DVALID,
        output D_ADR, D_DIN, D_WE, D_RE,
        input  D_DOUT, D_BUSY, D_DOUTVALID
    );

    modport slave (
        output P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADR, P1_ADR, P0_DIN, P1_DIN,
        input  P0_ACK, P1_ACK, P0_DOUT, P1_DOUT, P0_DVALID, P1_DVALID,
        input  D_ADR, D_DIN, D_WE, D_RE,
        output D_DOUT, D_BUSY, D_DOUTVALID
    );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a DRAM controller user port.
// One command at a time; reads block further grants until the data returns.
module dram_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 128
) (
    input  logic           CLK,
    input  logic           RST_X,
    input  logic           calib_done,
    dram_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RDWAIT} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] din_q, din_d;
    logic          we_q, we_d, re_q, re_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          dv0_q, dv0_d, dv1_q, dv1_d;
    logic [DW-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
    logic          win, win_we;

    // Tie goes to the port not granted last; a lone requester always wins.
    assign win    = (bus.P0_REQ && bus.P1_REQ) ? ~last_q : bus.P1_REQ;
    assign win_we = win ? bus.P1_WE : bus.P0_WE;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        adr_d   = adr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        dv0_d   = 1'b0;
        dv1_d   = 1'b0;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        case (state_q)
            IDLE: begin
                if (calib_done && !bus.D_BUSY && (bus.P0_REQ || bus.P1_REQ)) begin
                    state_d = ISSUE;
                    last_d  = win;
                    adr_d   = win ? bus.P1_ADR : bus.P0_ADR;
                    din_d   = win ? bus.P1_DIN : bus.P0_DIN;
                    we_d    = win_we;
                    re_d    = ~win_we;
                    ack0_d  = ~win;
                    ack1_d  = win;
                end
            end
            // re_q is still high during ISSUE for a read, so no separate type flag.
            ISSUE: state_d = re_q ? RDWAIT : GAP;
            GAP:   state_d = IDLE;
            RDWAIT: begin
                // last_q doubles as the owner of the outstanding read.
                if (bus.D_DOUTVALID) begin
                    state_d = IDLE;
                    if (last_q) begin
                        dout1_d = bus.D_DOUT;
                        dv1_d   = 1'b1;
                    end else begin
                        dout0_d = bus.D_DOUT;
                        dv0_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            adr_q   <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dv0_q   <= 1'b0;
            dv1_q   <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            dv0_q   <= dv0_d;
            dv1_q   <= dv1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign bus.D_ADR     = adr_q;
    assign bus.D_DIN     = din_q;
    assign bus.D_WE      = we_q;
    assign bus.D_RE      = re_q;
    assign bus.P0_ACK    = ack0_q;
    assign bus.P1_ACK    = ack1_q;
    assign bus.P0_DVALID = dv0_q;
    assign bus.P1_DVALID = dv1_q;
    assign bus.P0_DOUT   = dout0_q;
    assign bus.P1_DOUT   = dout1_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: cycle vector table plus hand-written
// sequences for calibration gating, alternation, read return, busy and reset.
module tb_dram_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam logic [AW-1:0] A0 = 32'h0000_0100;
    localparam logic [AW-1:0] A1 = 32'h0000_0010;
    localparam logic [DW-1:0] DIN0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_0A0A;
    localparam logic [DW-1:0] DIN1 = 128'hB1B1_9999_8888_7777_6666_5555_4444_1B1B;
    localparam logic [DW-1:0] DVA  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    localparam logic [DW-1:0] RD31 = {32'h1C, 32'h18, 32'h14, 32'h10};

    logic CLK = 1'b0;
    logic RST_X;
    logic calib_done;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    dram_arbiter_if #(.AW(AW), .DW(DW)) ifc ();
    dram_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .calib_done (calib_done),
        .bus        (ifc.master)
    );

    typedef struct packed {
        logic c, b, r0, w0, r1, w1, dv;
        logic we, re, a0, a1, v0, v1;
        logic [1:0] sel;   // 0: D_ADR/D_DIN reset, 1: port0 values, 2: port1 values
        logic d0;          // P0_DOUT: 0 or DVA
    } vec_t;

    vec_t tbl [18];
    int   gport [8];
    int   gcyc  [8];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.P0_REQ = 0; ifc.P0_WE = 0; ifc.P0_ADR = A0; ifc.P0_DIN = DIN0;
        ifc.P1_REQ = 0; ifc.P1_WE = 0; ifc.P1_ADR = A1; ifc.P1_DIN = DIN1;
        ifc.D_DOUT = '0; ifc.D_BUSY = 0; ifc.D_DOUTVALID = 0;
        calib_done = 1;
    endtask

    task automatic do_reset();
        RST_X = 0;
        clear_inputs();
        tick();
        RST_X = 1;
        tick();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_adr"}, ifc.D_ADR, '0);
        chk({nm, "_din"}, ifc.D_DIN, '0);
        chk({nm, "_cmd"}, {ifc.D_WE, ifc.D_RE, ifc.P0_ACK, ifc.P1_ACK, ifc.P0_DVALID, ifc.P1_DVALID}, '0);
        chk({nm, "_dout0"}, ifc.P0_DOUT, '0);
        chk({nm, "_dout1"}, ifc.P1_DOUT, '0);
    endtask

    initial begin
        int bad;
        int ng;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edin;

        //           c  b  r0 w0 r1 w1 dv  we re a0 a1 v0 v1 sel d0
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd1,1'b1};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b1};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b1};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b1};
        tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,1'b1};
        tbl[17] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd1,1'b1};

        // Reset state, then calibration gating of a pending write.
        do_reset();
        chk_reset_outputs("rst");
        calib_done = 0;
        ifc.P0_REQ = 1; ifc.P0_WE = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.D_WE || ifc.D_RE || ifc.P0_ACK) bad++;
        end
        chk("calib_hold", bad, 0);
        calib_done = 1;
        tick();
        chk("calib_we", {ifc.D_WE, ifc.D_RE, ifc.P0_ACK, ifc.P1_ACK}, 4'b1010);
        chk("calib_adr", ifc.D_ADR, A0);
        ifc.P0_REQ = 0;
        tick();
        chk("calib_pulse", {ifc.D_WE, ifc.P0_ACK}, 2'b00);
        chk("calib_hold_adr", ifc.D_ADR, A0);

        // Vector table, from a fresh reset.
        do_reset();
        ifc.D_DOUT = DVA;
        for (int i = 0; i < 18; i++) begin
            calib_done = tbl[i].c; ifc.D_BUSY = tbl[i].b;
            ifc.P0_REQ = tbl[i].r0; ifc.P0_WE = tbl[i].w0;
            ifc.P1_REQ = tbl[i].r1; ifc.P1_WE = tbl[i].w1;
            ifc.D_DOUTVALID = tbl[i].dv;
            tick();
            eadr = (tbl[i].sel == 2'd1) ? A0 : (tbl[i].sel == 2'd2) ? A1 : '0;
            edin = (tbl[i].sel == 2'd1) ? DIN0 : (tbl[i].sel == 2'd2) ? DIN1 : '0;
            chk($sformatf("v%0d_ctl", i),
                {ifc.D_WE, ifc.D_RE, ifc.P0_ACK, ifc.P1_ACK, ifc.P0_DVALID, ifc.P1_DVALID},
                {tbl[i].we, tbl[i].re, tbl[i].a0, tbl[i].a1, tbl[i].v0, tbl[i].v1});
            chk($sformatf("v%0d_adr", i), ifc.D_ADR, eadr);
            chk($sformatf("v%0d_din", i), ifc.D_DIN, edin);
            chk($sformatf("v%0d_dout0", i), ifc.P0_DOUT, tbl[i].d0 ? DVA : '0);
            chk($sformatf("v%0d_dout1", i), ifc.P1_DOUT, '0);
        end

        // Both ports writing continuously: strict alternation, 3-cycle spacing.
        do_reset();
        ifc.P0_REQ = 1; ifc.P0_WE = 1; ifc.P1_REQ = 1; ifc.P1_WE = 1;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
            tick();
            if (ifc.D_WE) begin
                gport[ng] = ifc.P1_ACK ? 1 : 0;
                gcyc[ng]  = cyc;
                ng++;
            end
        end
        chk("rr_count", ng, 6);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr_port%0d", k), gport[k], k % 2);
            if (k > 0) chk($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        clear_inputs();

        // P1 read returns data only to P1, one cycle after DOUTVALID.
        do_reset();
        ifc.P1_REQ = 1; ifc.P1_WE = 0; ifc.P1_ADR = 32'h0000_0010;
        tick();
        chk("rd_issue", {ifc.D_WE, ifc.D_RE, ifc.P0_ACK, ifc.P1_ACK}, 4'b0101);
        chk("rd_adr", ifc.D_ADR, 32'h0000_0010);
        ifc.P1_REQ = 0;
        ifc.P0_REQ = 1; ifc.P0_WE = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ifc.D_WE || ifc.D_RE || ifc.P0_ACK || ifc.P0_DVALID || ifc.P1_DVALID) bad++;
        end
        chk("rd_wait_quiet", bad, 0);
        ifc.P0_REQ = 0;
        ifc.D_DOUT = RD31; ifc.D_DOUTVALID = 1;
        tick();
        ifc.D_DOUTVALID = 0; ifc.D_DOUT = '0;
        chk("rd_dvalid", {ifc.P0_DVALID, ifc.P1_DVALID}, 2'b01);
        chk("rd_dout1", ifc.P1_DOUT, RD31);
        chk("rd_dout0", ifc.P0_DOUT, '0);
        tick();
        chk("rd_dvalid_pulse", {ifc.P0_DVALID, ifc.P1_DVALID}, 2'b00);
        chk("rd_dout1_hold", ifc.P1_DOUT, RD31);

        // D_BUSY blocks arbitration; command follows its release by one cycle.
        do_reset();
        ifc.D_BUSY = 1; ifc.P0_REQ = 1; ifc.P0_WE = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.D_WE || ifc.D_RE || ifc.P0_ACK) bad++;
        end
        chk("busy_hold", bad, 0);
        ifc.D_BUSY = 0;
        tick();
        chk("busy_release", {ifc.D_WE, ifc.P0_ACK}, 2'b11);
        clear_inputs();

        // Reset while a read is outstanding; late DOUTVALID must be ignored.
        do_reset();
        ifc.P0_REQ = 1; ifc.P0_WE = 0;
        tick();
        chk("rr_rd_issue", {ifc.D_RE, ifc.P0_ACK}, 2'b11);
        ifc.P0_REQ = 0;
        tick();
        #2 RST_X = 0;
        #1 chk_reset_outputs("async_rst");
        tick();
        RST_X = 1;
        tick();
        ifc.D_DOUT = RD31; ifc.D_DOUTVALID = 1;
        tick();
        ifc.D_DOUTVALID = 0;
        chk("late_dv", {ifc.P0_DVALID, ifc.P1_DVALID}, 2'b00);
        chk("late_dout0", ifc.P0_DOUT, '0);
        ifc.P1_REQ = 1; ifc.P1_WE = 1;
        tick();
        chk("post_rst_grant", {ifc.D_WE, ifc.D_RE, ifc.P0_ACK, ifc.P1_ACK}, 4'b1001);
        chk("post_rst_adr", ifc.D_ADR, A1);
        chk("post_rst_din", ifc.D_DIN, DIN1);
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
